slc3_mem_responder: RTL and testbench
=====================================

Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 datapath's MAR/MDR memory interface.
- Accepts level-strobed read/write requests addressed by MAR and services them from an on-chip word RAM.
- Address xFFFF is memory-mapped I/O: reads return the board switches, writes load the hex display register.
- Inserts programmable wait states and signals completion with a one-cycle ready pulse R, which the control FSM uses to leave its memory states.

Parameters:
- ADDR_WIDTH, 10, RAM depth is 2**ADDR_WIDTH 16-bit words.
- WAIT_STATES, 2, extra cycles between request acceptance and R (0..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous reset, active-low (asserted when 0).
- MAR  in  16  request address; stable while a strobe is high.
- MDR  in  16  write data; stable while MEM_WE is high.
- MEM_RD  in  1  read strobe, level.
- MEM_WE  in  1  write strobe, level.
- Switches  in  10  board switches, read at xFFFF.
- MDR_In  out  16  read data to the datapath MDR mux.
- R  out  1  ready; one-cycle pulse marking completion.
- Busy  out  1  high in every state other than IDLE.
- Hex_Reg  out  16  display register written at xFFFF.
- Err  out  1  out-of-range flag (see Optional Feature).

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - MDR_In=0, R=0, Busy=0, Hex_Reg=0, Err=0, wait counter=0.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE: on the edge E0 where MEM_RD or MEM_WE is sampled high:
  - Capture MAR, MDR and the operation.
  - If both strobes are high, the operation is a write.
  - Load the counter with WAIT_STATES and go to WAIT.
- WAIT: the counter decrements each edge. At the edge where the counter is 0, go to RESP.
- Latency: R is high for exactly the cycle after edge E0+WAIT_STATES+1. With WAIT_STATES=0, R is high after E1.
- Entering RESP (same edge R rises):
  - Write: commit the captured data to RAM[addr[ADDR_WIDTH-1:0]], or to Hex_Reg if addr=xFFFF.
  - Read: update MDR_In with RAM data, or with {6'b0, Switches} if addr=xFFFF.
- MDR_In holds its value until the next read completes. Writes never change MDR_In.
- RESP always goes to HOLD on the next edge; R falls.
- HOLD: stay while either strobe is high; go to IDLE once both are low.
  - One request produces exactly one R pulse, however long the strobe is held.
  - A new request needs the strobes to drop for at least one sampled cycle.
- MAR/MDR changes after E0 are ignored because the captured copies are used.
- Reset asserted in WAIT aborts the access: no RAM or Hex_Reg update and no R.
- RAM is synchronous single-port. Reads use the captured address, so the read value is the RAM contents at the commit edge.

Optional Feature:
- Macro SLC3_MEM_OOR_ERR_EN.
- Defined: any address other than xFFFF with bits [15:ADDR_WIDTH] nonzero is out of range.
  - Reads return x DEAD on MDR_In.
  - Writes are dropped.
  - Err pulses high together with R, for the same cycle.
  - The access still completes normally, with R and HOLD as usual.
- Undefined: the upper address bits are ignored, so addresses alias into RAM, and Err is tied to 0.

Test Plan:
1. WAIT_STATES=2: write MAR=x0010, MDR=x1234 at E0, then read x0010 -> R high only after E3 for each access; after the read, MDR_In=x1234 and Busy is high from E0 until HOLD exits.
2. Switches=10'h2A5, read xFFFF -> MDR_In=x02A5. Then write xBEEF to xFFFF -> Hex_Reg=xBEEF, RAM[x3FF] unchanged, MDR_In still x02A5.
3. MEM_RD held high for 20 cycles on x0010 -> exactly one R pulse. Drop MEM_RD for one cycle and reassert it -> a second R pulse WAIT_STATES+1 edges later.
4. MEM_RD=MEM_WE=1, MAR=x0020, MDR=x5555 -> treated as a write: RAM[x20]=x5555 on a later read, and MDR_In is unchanged by this access.
5. Start a write of xAAAA to x0030 and pulse Reset low during WAIT -> no R pulse, outputs at reset values, and a later read of x0030 returns the prior contents.
6. ADDR_WIDTH=10, read x0400:
   - Macro defined -> MDR_In=xDEAD, and Err and R high in the same cycle.
   - Macro undefined -> returns RAM[x000], Err=0.

Source files
------------

// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder
//   Memory-side responder for the SLC-3 MAR/MDR interface. A level-strobed
//   read or write is captured in IDLE. It then waits WAIT_STATES extra cycles
//   and completes with a single-cycle ready pulse R. Address xFFFF is
//   memory-mapped I/O: reads return the board switches, and writes load the
//   hex display register. All other addresses go to an on-chip word RAM.
//
//   Optional feature macro: SLC3_MEM_OOR_ERR_EN
//     defined   - addresses other than xFFFF with bits [15:ADDR_WIDTH] set
//                 are out of range: reads return xDEAD, writes are dropped,
//                 and Err pulses together with R.
//     undefined - upper address bits are ignored (aliasing), and Err is 0.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous reset, active-low
//   MAR       in   [15:0] request address
//   MDR       in   [15:0] write data
//   MEM_RD    in   read strobe (level)
//   MEM_WE    in   write strobe (level); wins over MEM_RD
//   Switches  in   [9:0] board switches, read at xFFFF
//   MDR_In    out  [15:0] read data, held until the next read completes
//   R         out  one-cycle completion pulse
//   Busy      out  high whenever the responder is not idle
//   Hex_Reg   out  [15:0] display register written at xFFFF
//   Err       out  out-of-range flag, coincident with R
module slc3_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        MEM_RD,
  input  logic        MEM_WE,
  input  logic [9:0]  Switches,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        Busy,
  output logic [15:0] Hex_Reg,
  output logic        Err
);

  localparam int          DATA_W   = 16;
  localparam int          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);
  localparam logic [15:0] IO_ADDR  = 16'hFFFF;
  localparam logic [15:0] OOR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      wr_q, wr_d;
  logic [15:0]               addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]         mdr_in_q, mdr_in_d;
  logic [DATA_W-1:0]         hex_q, hex_d;
  logic [DATA_W-1:0]         ram_q [DEPTH];
  logic                      ram_we;
  logic [ADDR_WIDTH-1:0]     idx;
  logic                      is_io;
  logic                      oor;

  assign idx   = addr_q[ADDR_WIDTH-1:0];
  assign is_io = (addr_q == IO_ADDR);

`ifdef SLC3_MEM_OOR_ERR_EN
  assign oor = !is_io && (addr_q[15:ADDR_WIDTH] != '0);
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mdr_in_d = mdr_in_q;
    hex_d    = hex_q;
    ram_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MEM_RD || MEM_WE) begin
          addr_d  = MAR;
          wdata_d = MDR;
          wr_d    = MEM_WE;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // The commit edge is also the edge on which R rises.
          state_d = S_RESP;
          if (wr_q) begin
            if (is_io)     hex_d  = wdata_q;
            else if (!oor) ram_we = 1'b1;
          end else begin
            if (is_io)     mdr_in_d = {6'b0, Switches};
            else if (oor)  mdr_in_d = OOR_DATA;
            else           mdr_in_d = ram_q[idx];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_HOLD;
      // Strobes must drop before another request is accepted, so a held
      // strobe cannot produce a second R.
      S_HOLD: if (!MEM_RD && !MEM_WE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      mdr_in_q <= '0;
      hex_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      mdr_in_q <= mdr_in_d;
      hex_q    <= hex_d;
    end
  end

  // Captured request data: qualified by state, so it needs no reset.
  always_ff @(posedge Clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // The RAM is not reset. An access aborted by reset never reaches the
  // commit because the state is forced back to IDLE.
  always_ff @(posedge Clk) begin
    if (ram_we) ram_q[idx] <= wdata_q;
  end

  assign MDR_In  = mdr_in_q;
  assign Hex_Reg = hex_q;
  assign R       = (state_q == S_RESP);
  assign Busy    = (state_q != S_IDLE);
  assign Err     = R && oor;

endmodule

// File: tb/tb_slc3_mem_responder.sv
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] MAR, MDR;
  logic        MEM_RD, MEM_WE;
  logic [9:0]  Switches;
  logic [15:0] MDR_In, Hex_Reg;
  logic        R, Busy, Err;

  int n_checks = 0;
  int n_errors = 0;
  logic last_err;

  slc3_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .MEM_RD(MEM_RD),
    .MEM_WE(MEM_WE), .Switches(Switches), .MDR_In(MDR_In), .R(R),
    .Busy(Busy), .Hex_Reg(Hex_Reg), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One complete access. Strobes are driven at a falling edge, so the next
  // rising edge is E0. With WAIT_STATES=2, R is seen at the 4th falling edge.
  task automatic access(input string tag, input logic rd, input logic we,
                        input logic [15:0] addr, input logic [15:0] data);
    int lat;
    lat = 0;
    last_err = 1'b0;
    @(negedge Clk);
    MAR = addr; MDR = data; MEM_RD = rd; MEM_WE = we;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (i == 1) check({tag, "_busy_e0"}, Busy, 1);
      if (R) begin
        lat = i;
        last_err = Err;
        break;
      end
    end
    check({tag, "_latency"}, lat, 4);
    MEM_RD = 1'b0; MEM_WE = 1'b0;
    MAR = 16'h0BAD; MDR = 16'h0BAD;
    @(negedge Clk);
    check({tag, "_hold_r"}, R, 0);
    check({tag, "_hold_busy"}, Busy, 1);
    @(negedge Clk);
    check({tag, "_idle_busy"}, Busy, 0);
  endtask

  initial begin
    int pulses;
    Reset = 1'b0; MAR = '0; MDR = '0; MEM_RD = 0; MEM_WE = 0;
    Switches = 10'h2A5;
    #12;
    check("rst_mdr_in", MDR_In, 0);
    check("rst_r", R, 0);
    check("rst_busy", Busy, 0);
    check("rst_hex", Hex_Reg, 0);
    check("rst_err", Err, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Test 1: basic write, then read back
    access("wr10", 0, 1, 16'h0010, 16'h1234);
    check("wr10_mdr_in_unchanged", MDR_In, 16'h0000);
    access("rd10", 1, 0, 16'h0010, 16'h0000);
    check("rd10_data", MDR_In, 16'h1234);

    access("wr3ff", 0, 1, 16'h03FF, 16'h7777);
    access("wr000", 0, 1, 16'h0000, 16'h1111);

    // Test 2: memory-mapped I/O
    access("rdio", 1, 0, 16'hFFFF, 16'h0000);
    check("rdio_data", MDR_In, 16'h02A5);
    access("wrio", 0, 1, 16'hFFFF, 16'hBEEF);
    check("wrio_hex", Hex_Reg, 16'hBEEF);
    check("wrio_mdr_in", MDR_In, 16'h02A5);
    access("rd3ff", 1, 0, 16'h03FF, 16'h0000);
    check("rd3ff_data", MDR_In, 16'h7777);

    // Test 4: both strobes high means write
    access("both", 1, 1, 16'h0020, 16'h5555);
    check("both_mdr_in", MDR_In, 16'h7777);
    access("rd20", 1, 0, 16'h0020, 16'h0000);
    check("rd20_data", MDR_In, 16'h5555);

    // Test 3: a held strobe yields one pulse; drop one cycle, get another
    @(negedge Clk);
    MAR = 16'h0010; MEM_RD = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (R) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_data", MDR_In, 16'h1234);
    MEM_RD = 1'b0;
    access("reassert", 1, 0, 16'h0010, 16'h0000);

    // Test 5: reset during WAIT aborts the write
    access("wr30", 0, 1, 16'h0030, 16'hC3C3);
    @(negedge Clk);
    MAR = 16'h0030; MDR = 16'hAAAA; MEM_WE = 1'b1;
    @(negedge Clk);
    check("abort_in_wait", Busy, 1);
    Reset = 1'b0;
    #1;
    check("abort_r", R, 0);
    check("abort_busy", Busy, 0);
    check("abort_mdr_in", MDR_In, 0);
    check("abort_hex", Hex_Reg, 0);
    @(negedge Clk);
    MEM_WE = 1'b0;
    Reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (R) pulses++;
    end
    check("abort_no_r", pulses, 0);
    access("rd30", 1, 0, 16'h0030, 16'h0000);
    check("rd30_prior", MDR_In, 16'hC3C3);

    // Test 6: out-of-range address
    access("rd400", 1, 0, 16'h0400, 16'h0000);
`ifdef SLC3_MEM_OOR_ERR_EN
    check("rd400_data", MDR_In, 16'hDEAD);
    check("rd400_err", last_err, 1);
`else
    check("rd400_data", MDR_In, 16'h1111);
    check("rd400_err", last_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
